// File: rtl/codif_pkg.sv
// Shared definitions for the RV32I instruction encoder: type codes, opcodes,
// error codes and the NOP word used as the reset value of the output register.
package codif_pkg;

    typedef enum logic [2:0] {
        TIPO_I = 3'd0,
        TIPO_R = 3'd1,
        TIPO_S = 3'd2,
        TIPO_L = 3'd3,
        TIPO_B = 3'd4,
        TIPO_J = 3'd5
    } tipo_e;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TIPO = 2'b01;
    localparam logic [1:0] ERR_IMM  = 2'b10;

    localparam logic [31:0] NOP = 32'h00000013;

    // Immediate-form shifts (slli/srli/srai) carry funct7 plus a 5-bit shamt.
    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/codificador_campos.sv
// Combinational field packer: builds the 32-bit RV32I word for one request and
// flags illegal types; immediate range checks exist only with CODIF_CHECK_IMM_EN.
module codificador_campos
    import codif_pkg::*;
(
    input  logic [2:0]  tipo_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        tipo_ok_o,
    output logic        imm_ok_o
);

    logic shift_s;
    assign shift_s = is_shift(funct3_i);

    // Field packing per instruction format
    always_comb begin
        instr_o   = NOP;
        tipo_ok_o = 1'b1;
        case (tipo_i)
            TIPO_I: begin
                if (shift_s) begin
                    instr_o = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, OP_I};
                end else begin
                    instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_I};
                end
            end
            TIPO_R: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
            TIPO_S: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
            TIPO_L: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_L};
            TIPO_B: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], OP_B};
            TIPO_J: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_J};
            default: tipo_ok_o = 1'b0;
        endcase
    end

`ifdef CODIF_CHECK_IMM_EN
    logic fits12_s, fits13_s, fits21_s;
    assign fits12_s = (imm_i[31:11] == {21{imm_i[11]}});
    assign fits13_s = (imm_i[31:12] == {20{imm_i[12]}});
    assign fits21_s = (imm_i[31:20] == {12{imm_i[20]}});

    // Immediate range and alignment per format
    always_comb begin
        imm_ok_o = 1'b1;
        case (tipo_i)
            TIPO_I: begin
                if (shift_s) begin
                    imm_ok_o = (imm_i[31:5] == 27'd0);
                end else begin
                    imm_ok_o = fits12_s;
                end
            end
            TIPO_S:  imm_ok_o = fits12_s;
            TIPO_L:  imm_ok_o = fits12_s;
            TIPO_B:  imm_ok_o = fits13_s && !imm_i[0];
            TIPO_J:  imm_ok_o = fits21_s && !imm_i[0];
            default: imm_ok_o = 1'b1;
        endcase
    end
`else
    // Without checks the upper immediate bits and bit 0 are silently dropped.
    logic unused_imm_s;
    assign unused_imm_s = ^{imm_i[31:21], imm_i[0]};
    assign imm_ok_o     = 1'b1;
`endif

endmodule

// File: rtl/codificador_instr.sv
// Instruction encoder top: valid/ready intake, registered memory write port with
// auto-incrementing address, fill counter and error pulse. Macro: CODIF_CHECK_IMM_EN.
module codificador_instr
    import codif_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int BASE   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        tipo_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       instr_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

    logic [31:0]       word_s;
    logic              tipo_ok_s, imm_ok_s, accept_s;
    logic              we_q, we_d, full_q, full_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W:0]   count_q, count_d, count_inc_s;
    logic [1:0]        code_q, code_d;

    codificador_campos u_campos (
        .tipo_i    (tipo_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .imm_i     (imm_i),
        .instr_o   (word_s),
        .tipo_ok_o (tipo_ok_s),
        .imm_ok_o  (imm_ok_s)
    );

    assign ready_o     = !clear_i && !full_q;
    assign accept_s    = valid_i && ready_o;
    assign count_inc_s = count_q + (ADDR_W+1)'(1);

    // Next-state: clear wins over acceptance; address wraps modulo 2**ADDR_W
    always_comb begin
        we_d    = 1'b0;
        addr_d  = addr_q;
        instr_d = instr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        if (clear_i) begin
            count_d = '0;
            full_d  = 1'b0;
        end else if (accept_s) begin
            if (!tipo_ok_s) begin
                err_d  = 1'b1;
                code_d = ERR_TIPO;
            end else if (!imm_ok_s) begin
                err_d  = 1'b1;
                code_d = ERR_IMM;
            end else begin
                we_d    = 1'b1;
                addr_d  = BASE_C + count_q[ADDR_W-1:0];
                instr_d = word_s;
                count_d = count_inc_s;
                full_d  = (count_inc_s == DEPTH_C);
            end
        end else begin
            we_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            instr_q <= NOP;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign we_o       = we_q;
    assign addr_o     = addr_q;
    assign instr_o    = instr_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_codificador_instr.sv
// Directed scoreboard bench for codificador_instr with DEPTH=4, BASE=2.
module tb_codificador_instr;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;
    localparam int BASE   = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1, clear_i = 1'b0, valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  tipo_i = 3'd0;
    logic [4:0]  rd_i = 5'd0, rs1_i = 5'd0, rs2_i = 5'd0;
    logic [2:0]  funct3_i = 3'd0;
    logic [6:0]  funct7_i = 7'd0;
    logic [31:0] imm_i = 32'd0;
    logic        we_o, full_o, err_o;
    logic [7:0]  addr_o;
    logic [31:0] instr_o;
    logic [8:0]  count_o;
    logic [1:0]  err_code_o;

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] instr;
        logic [8:0]  count;
        logic        full;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  m_addr;
    logic [31:0] m_instr;
    int          m_count;
    logic        m_full;

    always #5 clk = ~clk;

    codificador_instr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .valid_i(valid_i),
        .ready_o(ready_o), .tipo_i(tipo_i), .rd_i(rd_i), .rs1_i(rs1_i),
        .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
        .we_o(we_o), .addr_o(addr_o), .instr_o(instr_o), .count_o(count_o),
        .full_o(full_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, instr_o);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".we"},    32'(we_o),       32'(e.we));
            chk({tag, ".addr"},  32'(addr_o),     32'(e.addr));
            chk({tag, ".instr"}, instr_o,         e.instr);
            chk({tag, ".count"}, 32'(count_o),    32'(e.count));
            chk({tag, ".full"},  32'(full_o),     32'(e.full));
            chk({tag, ".err"},   32'(err_o),      32'(e.err));
            chk({tag, ".code"},  32'(err_code_o), 32'(e.code));
        end
    endtask

    // bad = 0 means a legal request expected to write word; else the error code
    task automatic step(input string tag, input logic v, input logic clr,
                        input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] word, input logic [1:0] bad);
        exp_t e;
        logic rdy;
        valid_i = v; clear_i = clr; tipo_i = t; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        funct3_i = f3; funct7_i = f7; imm_i = imm;
        #1;
        rdy = !clr && !m_full;
        chk({tag, ".ready"}, 32'(ready_o), 32'(rdy));
        e.we = 1'b0; e.err = 1'b0; e.code = 2'b00;
        if (clr) begin
            m_count = 0;
            m_full  = 1'b0;
        end else if (v && rdy) begin
            if (bad != 2'b00) begin
                e.err  = 1'b1;
                e.code = bad;
            end else begin
                e.we    = 1'b1;
                m_addr  = 8'((BASE + m_count) % 256);
                m_instr = word;
                m_count = m_count + 1;
                m_full  = (m_count == DEPTH);
            end
        end
        e.addr = m_addr; e.instr = m_instr; e.count = 9'(m_count); e.full = m_full;
        sb_q.push_back(e);
        @(posedge clk); #1;
        valid_i = 1'b0; clear_i = 1'b0;
        compare_out(tag);
    endtask

    task automatic do_reset(input string tag, input logic v);
        exp_t e;
        rst_i = 1'b1; valid_i = v;
        m_addr = 8'd0; m_instr = 32'h00000013; m_count = 0; m_full = 1'b0;
        e = '{we: 1'b0, addr: 8'd0, instr: 32'h00000013, count: 9'd0,
              full: 1'b0, err: 1'b0, code: 2'b00};
        sb_q.push_back(e);
        @(posedge clk); #1;
        rst_i = 1'b0; valid_i = 1'b0;
        compare_out(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset", 1'b0);
        step("add",   1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 2'b00);
        step("addi",  1'b1, 1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293, 2'b00);
        step("tipo7", 1'b1, 1'b0, 3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 2'b01);
        step("tipo6", 1'b1, 1'b0, 3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'd0, 2'b01);
        step("idle",  1'b0, 1'b0, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00);
        step("beq",   1'b1, 1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 2'b00);
        step("jal",   1'b1, 1'b0, 3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 2'b00);
        step("full_ign", 1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 2'b00);
        step("full_bad", 1'b1, 1'b0, 3'd7, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'd0, 2'b01);
        step("clear_v",  1'b1, 1'b1, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 2'b00);
        step("sw",    1'b1, 1'b0, 3'd2, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 32'h0020A423, 2'b00);
        step("lw",    1'b1, 1'b0, 3'd3, 5'd5, 5'd1, 5'd0, 3'd2, 7'd0, 32'd4, 32'h0040A283, 2'b00);
        step("srai",  1'b1, 1'b0, 3'd0, 5'd6, 5'd7, 5'd0, 3'd5, 7'b0100000, 32'd3, 32'h4033D313, 2'b00);
`ifdef CODIF_CHECK_IMM_EN
        step("b_odd",   1'b1, 1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'd0, 2'b10);
        step("i_range", 1'b1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'd0, 2'b10);
        step("sh_range", 1'b1, 1'b0, 3'd0, 5'd1, 5'd0, 5'd0, 3'd1, 7'd0, 32'd32, 32'd0, 2'b10);
`else
        step("b_odd",   1'b1, 1'b0, 3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h00000163, 2'b00);
`endif
        step("burst", 1'b1, 1'b1, 3'd1, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 2'b00);
        step("b_add", 1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 2'b00);
        tipo_i = 3'd0; rd_i = 5'd5; imm_i = 32'hFFFFFFFF;
        do_reset("rst_burst", 1'b1);
        step("post_rst", 1'b1, 1'b0, 3'd1, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 2'b00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
